// File: rtl/instruction_loader.sv
// Byte-stream program loader: pairs bytes into instruction words, writes them to
// consecutive instruction-memory addresses, zero-fills the rest, then releases the CPU.
`timescale 1ns/1ps
module instruction_loader #(
   parameter int INSTRUCTION_WIDTH = 10,
   parameter int ADDR_BITS         = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         in_valid,
   input  logic [7:0]                   in_data,
   output logic                         in_ready,
   output logic                         mem_we,
   output logic [ADDR_BITS-1:0]         mem_addr,
   output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
   output logic                         cpu_hold,
   output logic                         busy,
   output logic                         done,
   output logic [ADDR_BITS:0]           count
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_GET_HI = 3'd1;
   localparam logic [2:0] S_GET_LO = 3'd2;
   localparam logic [2:0] S_WRITE  = 3'd3;
   localparam logic [2:0] S_FILL   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]                   state;
   logic [ADDR_BITS-1:0]         ptr;
   logic [ADDR_BITS:0]           cnt;
   logic [INSTRUCTION_WIDTH-9:0] hi_bits;
   logic [7:0]                   lo_bits;
   logic                         accept;
   logic                         last;

   assign accept = in_valid && in_ready;
   assign last   = &ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state <= S_GET_HI;
                  ptr   <= '0;
                  cnt   <= '0;
               end
            end
            S_GET_HI: begin
               if (accept) state <= in_data[7] ? S_FILL : S_GET_LO;
            end
            S_GET_LO: begin
               if (accept) state <= S_WRITE;
            end
            S_WRITE: begin
               cnt <= cnt + 1'b1;
               // The pointer never wraps: the last address finishes the load directly.
               if (last) begin
                  state <= S_DONE;
               end else begin
                  ptr   <= ptr + 1'b1;
                  state <= S_GET_HI;
               end
            end
            S_FILL: begin
               if (last) begin
                  state <= S_DONE;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Word assembly registers carry data only; stale contents are never written
   // because a write requires passing through GET_LO again.
   always_ff @(posedge clk) begin
      if (state == S_GET_HI && accept) hi_bits <= in_data[INSTRUCTION_WIDTH-9:0];
      if (state == S_GET_LO && accept) lo_bits <= in_data;
   end

   assign in_ready  = (state == S_GET_HI) || (state == S_GET_LO);
   assign mem_we    = (state == S_WRITE) || (state == S_FILL);
   assign mem_addr  = ptr;
   assign mem_wdata = (state == S_WRITE) ? {hi_bits, lo_bits} : '0;
   assign cpu_hold  = (state != S_DONE);
   assign busy      = (state == S_GET_HI) || (state == S_GET_LO) ||
                      (state == S_WRITE)  || (state == S_FILL);
   assign done      = (state == S_DONE);
   assign count     = cnt;

endmodule
